bmem_responder: RTL and testbench
=================================

Name: bmem_responder

Overview:
- Burst-memory responder: the target end of the 64-bit bmem interface that cache-side adapters drive.
- Accepts 256-bit cacheline reads and writes as single addresses plus 4×64-bit beats, and holds the lines in an internal array.
- Returns read data in order, after a fixed latency, with up to QDEPTH reads outstanding.
- Used as a synthesizable backing store and as a bench responder behind the icache/dcache arbiter.

Parameters:
LATENCY, 4, cycles from read acceptance to beat 0 when idle; legal range 2..15.
QDEPTH, 4, maximum outstanding (accepted, not fully returned) reads; power of two, at least 2.
LINES, 256, cachelines stored; index width IDX_W = $clog2(LINES).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
bmem_addr  in  32  request line address; bits [4:0] expected 0
bmem_read  in  1  read request, one cycle per line
bmem_write  in  1  write beat valid
bmem_wdata  in  64  write beat data
bmem_ready  out  1  request/beat accepted this cycle when high
bmem_raddr  out  32  address of the line being returned
bmem_rdata  out  64  read beat data
bmem_rvalid  out  1  read beat valid
protocol_err  out  1  sticky protocol violation flag (see Optional Feature)

Behaviour:
- Reset values: bmem_ready=0 in any cycle rst is high, then 1 from the first cycle after rst falls (unless the queue is full). bmem_rvalid=0, bmem_raddr=0, bmem_rdata=0, protocol_err=0. Read queue empty, beat engine idle, write beat counter 0.
- Array contents are not reset and are zero at time 0. Reset mid-burst drops all queued and in-flight reads and any partial write; none of the beats already received is committed.
- Line index = bmem_addr[5+IDX_W-1:5]. Upper bits alias (wrap modulo LINES). bits [4:0] are ignored.
- bmem_ready = !rst && (queue count < QDEPTH || write burst in progress).
- Read acceptance: bmem_read && bmem_ready && !bmem_write && no write burst in progress. Pushes {addr, countdown=LATENCY-1} into the queue. Countdowns decrement every cycle and saturate at 0.
- Beat engine states:
  - IDLE: when head countdown==0, go to BURST (beat 0 this cycle).
  - BURST: beats 0..3 on consecutive cycles with bmem_rvalid=1 and bmem_raddr=line addr. bmem_rdata = line[64*k +: 64] for beat k (beat 0 is the LSBs).
  - After beat 3: pop the head. If the new head's countdown is 0, its beat 0 follows in the next cycle (zero-gap back-to-back); otherwise return to IDLE.
- Read data is snapshotted from the array in the beat-0 cycle; all 4 beats come from that snapshot.
- Idle read at cycle T returns beats at T+LATENCY .. T+LATENCY+3.
- A queue pop and push in the same cycle keeps count unchanged. A read accepted while the queue is full is impossible because ready is low.
- Write: beat 0 accepted when bmem_write && bmem_ready. It latches the address and asserts the write-burst flag, which holds ready high.
  - Beats 1..3 are counted only on cycles with bmem_write=1. The address is taken from beat 0.
  - The line commits at the clock edge accepting beat 3 and is visible to any burst whose beat 0 is in a later cycle.
  - Writes bypass the queue and never stall reads already queued.
- Simultaneous bmem_read and bmem_write: write wins and the read is dropped.
- bmem_read during write beats 1..3 is dropped.

Optional Feature:
BMEM_PROTOCOL_CHECK_EN
- Defined: protocol_err sets (sticky until rst) on any of:
  - read and write high in the same cycle;
  - read during a write burst;
  - nonzero bmem_addr[4:0] on an accepted request;
  - bmem_addr on write beats 1..3 differing from beat 0;
  - bmem_read held high for 2 consecutive cycles with the same address while ready is high (duplicate issue).
- On the first error, the simulation also prints `$error` with the cycle and cause.
- Undefined: protocol_err is tied to 0, no checker logic is present, and behaviour is otherwise identical.

Test Plan:
- LATENCY=4, idle, preload line 0x40 = {D3,D2,D1,D0}. Read addr 0x40 at cycle 10 → rvalid cycles 14–17, raddr=0x40, rdata D0,D1,D2,D3. rvalid=0 at cycles 13 and 18.
- Reads 0x00, 0x20, 0x40 at cycles 10, 11, 12 → three 4-beat bursts with no gaps, cycles 14–25, in request order.
- QDEPTH=4: reads issued every cycle from cycle 0. Ready falls after 4 acceptances; the held 5th read is accepted the cycle after the first burst's beat 3 pops; all 5 bursts are returned in order.
- Write 0x80 with beats A,B,C,D (beat 1 idle one cycle, write=0), then read 0x80 → returns A,B,C,D. A read of 0x80 queued before the write commit but launching after it also returns A,B,C,D.
- Reset asserted during beat 1 of a burst with 2 more queued → rvalid=0 and ready=0 while rst is high. After reset, ready=1 and no further rvalid until a new read.
- With BMEM_PROTOCOL_CHECK_EN: read 0x44 → protocol_err=1 next cycle and stays 1 until rst. Without the macro, the same stimulus returns the 0x40 line and protocol_err stays 0.

Source files
------------

// File: rtl/bmem_responder_if.sv
// Burst-memory link between cache-side adapters (master) and the backing store (slave).
// Request side carries line reads and 64-bit write beats; response side returns 4-beat read bursts.
interface bmem_responder_if;
    logic [31:0] bmem_addr;
    logic        bmem_read;
    logic        bmem_write;
    logic [63:0] bmem_wdata;
    logic        bmem_ready;
    logic [31:0] bmem_raddr;
    logic [63:0] bmem_rdata;
    logic        bmem_rvalid;
    logic        protocol_err;

    modport master (
        output bmem_addr, bmem_read, bmem_write, bmem_wdata,
        input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid, protocol_err
    );

    modport slave (
        input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
        output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid, protocol_err
    );
endinterface

// File: rtl/bmem_responder.sv
// Burst-memory target: in-order 4-beat line reads LATENCY cycles after acceptance, up to QDEPTH outstanding.
// Ready drops only when QDEPTH reads are outstanding and no write burst is open; BMEM_PROTOCOL_CHECK_EN adds a sticky checker.
module bmem_responder #(
    parameter int LATENCY = 4,
    parameter int QDEPTH  = 4,
    parameter int LINES   = 256
) (
    input logic             clk,
    input logic             rst,
    bmem_responder_if.slave bmem
);
    localparam int IDX_W = $clog2(LINES);
    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = $clog2(QDEPTH + 1);

    typedef enum logic {S_IDLE, S_BURST} state_t;

    logic [255:0]     mem_q [LINES];
    logic [31:0]      qaddr_q [QDEPTH];
    logic [3:0]       qcd_q [QDEPTH];
    logic [PTR_W-1:0] head_q, tail_q;
    logic [CNT_W-1:0] count_q;

    state_t           state_q, state_d;
    logic [1:0]       beat_q, beat_d;
    logic [255:0]     line_q;

    logic             wr_busy_q;
    logic [1:0]       wcnt_q;
    logic [31:0]      waddr_q;
    logic [191:0]     wbuf_q;

    logic             ready, wr_acc, rd_acc, launch, pop, commit;
    logic [31:0]      head_addr;
    logic [IDX_W-1:0] head_idx;
    logic             rd_vld;
    logic [31:0]      rd_addr;
    logic [63:0]      rd_dat;

    assign ready     = !rst && ((count_q < CNT_W'(QDEPTH)) || wr_busy_q);
    assign wr_acc    = bmem.bmem_write && ready;
    assign rd_acc    = bmem.bmem_read && ready && !bmem.bmem_write && !wr_busy_q;
    assign head_addr = qaddr_q[head_q];
    assign head_idx  = head_addr[5 +: IDX_W];
    // Countdown saturates at 0, so an IDLE cycle after a pop launches the next head with no gap.
    assign launch    = !rst && (state_q == S_IDLE) && (count_q != '0) && (qcd_q[head_q] == 4'd0);
    assign pop       = !rst && (state_q == S_BURST) && (beat_q == 2'd3);
    assign commit    = !rst && wr_busy_q && bmem.bmem_write && (wcnt_q == 2'd3);

    assign bmem.bmem_ready  = ready;
    assign bmem.bmem_rvalid = rd_vld;
    assign bmem.bmem_raddr  = rd_addr;
    assign bmem.bmem_rdata  = rd_dat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            beat_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        case (state_q)
            S_IDLE: begin
                if (launch) begin
                    state_d = S_BURST;
                    beat_d  = 2'd1;
                end
            end
            S_BURST: begin
                beat_d = beat_q + 2'd1;
                if (beat_q == 2'd3) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Beat 0 comes straight from the array; beats 1..3 from the snapshot taken in that cycle.
    always_comb begin
        rd_vld  = 1'b0;
        rd_addr = '0;
        rd_dat  = '0;
        if (launch) begin
            rd_vld  = 1'b1;
            rd_addr = head_addr;
            rd_dat  = mem_q[head_idx][63:0];
        end else if (!rst && state_q == S_BURST) begin
            rd_vld  = 1'b1;
            rd_addr = head_addr;
            rd_dat  = line_q[64*beat_q +: 64];
        end
    end

    always_ff @(posedge clk) begin
        if (launch) line_q <= mem_q[head_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < QDEPTH; i++) qcd_q[i] <= 4'd0;
        end else begin
            for (int i = 0; i < QDEPTH; i++) begin
                if (rd_acc && tail_q == PTR_W'(i)) begin
                    qcd_q[i]   <= 4'(LATENCY - 1);
                    qaddr_q[i] <= {bmem.bmem_addr[31:5], 5'd0};
                end else if (qcd_q[i] != 4'd0) begin
                    qcd_q[i] <= qcd_q[i] - 4'd1;
                end
            end
            if (rd_acc) tail_q <= tail_q + PTR_W'(1);
            if (pop)    head_q <= head_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(rd_acc) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_busy_q <= 1'b0;
            wcnt_q    <= 2'd0;
        end else if (wr_acc) begin
            if (!wr_busy_q) begin
                wr_busy_q     <= 1'b1;
                wcnt_q        <= 2'd1;
                waddr_q       <= bmem.bmem_addr;
                wbuf_q[63:0]  <= bmem.bmem_wdata;
            end else if (wcnt_q == 2'd3) begin
                wr_busy_q <= 1'b0;
                wcnt_q    <= 2'd0;
            end else begin
                wbuf_q[64*wcnt_q +: 64] <= bmem.bmem_wdata;
                wcnt_q                  <= wcnt_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (commit) mem_q[waddr_q[5 +: IDX_W]] <= {bmem.bmem_wdata, wbuf_q};
    end

`ifdef BMEM_PROTOCOL_CHECK_EN
    logic        err_q, prev_rd_q, err_now;
    logic [31:0] prev_addr_q, cyc_q;
    logic        e_rw, e_rd_burst, e_align, e_waddr, e_dup;

    assign e_rw       = bmem.bmem_read && bmem.bmem_write;
    assign e_rd_burst = bmem.bmem_read && wr_busy_q;
    assign e_align    = (rd_acc || (wr_acc && !wr_busy_q)) && (bmem.bmem_addr[4:0] != 5'd0);
    assign e_waddr    = wr_busy_q && bmem.bmem_write && (bmem.bmem_addr != waddr_q);
    assign e_dup      = bmem.bmem_read && prev_rd_q && (bmem.bmem_addr == prev_addr_q) && ready;
    assign err_now    = !rst && (e_rw || e_rd_burst || e_align || e_waddr || e_dup);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q       <= 1'b0;
            prev_rd_q   <= 1'b0;
            prev_addr_q <= '0;
            cyc_q       <= '0;
        end else begin
            cyc_q       <= cyc_q + 32'd1;
            prev_rd_q   <= bmem.bmem_read;
            prev_addr_q <= bmem.bmem_addr;
            if (err_now && !err_q) begin
                err_q <= 1'b1;
                $error("bmem_responder: protocol violation at cycle %0d (rw=%0b rd_in_wr=%0b align=%0b waddr=%0b dup=%0b)",
                       cyc_q, e_rw, e_rd_burst, e_align, e_waddr, e_dup);
            end
        end
    end

    assign bmem.protocol_err = err_q;
`else
    logic unused_bits;
    assign unused_bits       = ^{bmem.bmem_addr[4:0], waddr_q[31:5+IDX_W], waddr_q[4:0]};
    assign bmem.protocol_err = 1'b0;
`endif
endmodule

// File: tb/tb_bmem_responder.sv
// Randomized bench for bmem_responder against a cycle-arithmetic reference model.
// Bursts are predicted as start = max(accept + LATENCY, previous start + 4) with data snapshotted at start.
module tb_bmem_responder;
    localparam int LAT = 4;
    localparam int QD  = 4;
    localparam int NL  = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;

    bmem_responder_if bus();

    bmem_responder #(.LATENCY(LAT), .QDEPTH(QD), .LINES(NL)) dut (
        .clk  (clk),
        .rst  (rst),
        .bmem (bus)
    );

    always #5 clk = ~clk;

    int           n_chk = 0;
    int           n_err = 0;
    int           cyc   = 0;

    logic [255:0] mmem [NL];
    int           q_start[$];
    logic [31:0]  q_addr[$];
    logic [255:0] snap;
    int           last_start;
    bit           wbusy;
    int           wcnt;
    logic [31:0]  waddr;
    logic [255:0] wline;
    bit           saw_req;

    bit           s_r, s_rd, s_wr;
    logic [31:0]  s_a;
    logic [63:0]  s_d;
    int unsigned  sel;

    task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, act, exp);
        end
    endtask

    task automatic tick(input bit r, input bit rd, input bit wr, input logic [31:0] a, input logic [63:0] d);
        int          k;
        int          st;
        bit          exp_rdy, exp_v;
        logic [31:0] ha;
        rst             = r;
        bus.bmem_read   = rd;
        bus.bmem_write  = wr;
        bus.bmem_addr   = a;
        bus.bmem_wdata  = d;
        @(negedge clk);
        while (q_start.size() > 0 && q_start[0] + 3 < cyc) begin
            void'(q_start.pop_front());
            void'(q_addr.pop_front());
        end
        exp_rdy = !r && (q_start.size() < QD || wbusy);
        exp_v   = 1'b0;
        k       = 0;
        ha      = '0;
        if (!r && q_start.size() > 0 && q_start[0] <= cyc) begin
            exp_v = 1'b1;
            k     = cyc - q_start[0];
            ha    = q_addr[0];
            if (k == 0) snap = mmem[ha[12:5]];
        end
        chk("ready", bus.bmem_ready, exp_rdy);
        chk("rvalid", bus.bmem_rvalid, exp_v);
        chk("perr", bus.protocol_err, 1'b0);
        if (exp_v) begin
            chk("raddr", bus.bmem_raddr, {ha[31:5], 5'd0});
            chk("rdata", bus.bmem_rdata, snap[64*k +: 64]);
        end else if (!saw_req) begin
            chk("raddr_rst", bus.bmem_raddr, 32'd0);
            chk("rdata_rst", bus.bmem_rdata, 64'd0);
        end

        if (r) begin
            q_start.delete();
            q_addr.delete();
            wbusy      = 1'b0;
            wcnt       = 0;
            last_start = -100;
            saw_req    = 1'b0;
        end else if (wr && exp_rdy) begin
            saw_req = 1'b1;
            if (!wbusy) begin
                wbusy        = 1'b1;
                wcnt         = 1;
                waddr        = a;
                wline[63:0]  = d;
            end else begin
                wline[64*wcnt +: 64] = d;
                if (wcnt == 3) begin
                    mmem[waddr[12:5]] = wline;
                    wbusy = 1'b0;
                end else begin
                    wcnt++;
                end
            end
        end else if (rd && exp_rdy && !wbusy) begin
            st = (cyc + LAT > last_start + 4) ? cyc + LAT : last_start + 4;
            q_start.push_back(st);
            q_addr.push_back(a);
            last_start = st;
            saw_req    = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 1'b0, 1'b0, 32'h0, 64'h0);
    endtask

    task automatic rd_line(input logic [31:0] a);
        tick(1'b0, 1'b1, 1'b0, a, 64'h0);
    endtask

    task automatic wr_beat(input logic [31:0] a, input logic [63:0] d);
        tick(1'b0, 1'b0, 1'b1, a, d);
    endtask

    initial begin
        for (int i = 0; i < NL; i++) mmem[i] = '0;
        last_start     = -100;
        wbusy          = 1'b0;
        wcnt           = 0;
        waddr          = '0;
        wline          = '0;
        snap           = '0;
        saw_req        = 1'b0;
        bus.bmem_read  = 1'b0;
        bus.bmem_write = 1'b0;
        bus.bmem_addr  = '0;
        bus.bmem_wdata = '0;
        @(posedge clk);
        #1;

        repeat (3) tick(1'b1, 1'b0, 1'b0, 32'h0, 64'h0);
        idle(3);

        // Preload lines 0..15, with a write-idle gap inside some bursts.
        for (int l = 0; l < 16; l++) begin
            for (int b = 0; b < 4; b++) begin
                if (b == 1 && (l % 3) == 0) idle(1);
                wr_beat(32'(l * 32), {$urandom, $urandom});
            end
        end

        idle(4);
        rd_line(32'h40);
        idle(8);

        rd_line(32'h00);
        rd_line(32'h20);
        rd_line(32'h40);
        idle(16);

        for (int i = 0; i < 24; i++) rd_line(32'((i % 16) * 32));
        idle(24);

        wr_beat(32'h80, 64'hAAAA_0000_0000_000A);
        idle(1);
        wr_beat(32'h80, 64'hBBBB_0000_0000_000B);
        wr_beat(32'h80, 64'hCCCC_0000_0000_000C);
        wr_beat(32'h80, 64'hDDDD_0000_0000_000D);
        rd_line(32'h80);
        idle(8);

        rd_line(32'h20);
        rd_line(32'h80);
        wr_beat(32'h80, 64'h1111_2222_3333_4444);
        wr_beat(32'h80, 64'h5555_6666_7777_8888);
        wr_beat(32'h80, 64'h9999_AAAA_BBBB_CCCC);
        wr_beat(32'h80, 64'hDDDD_EEEE_FFFF_0000);
        idle(14);

        // Reset lands on beat 1 of the first of three queued bursts.
        rd_line(32'h00);
        rd_line(32'h20);
        rd_line(32'h40);
        idle(2);
        repeat (2) tick(1'b1, 1'b0, 1'b0, 32'h0, 64'h0);
        idle(10);

        rd_line(32'h44);
        idle(8);

        for (int n = 0; n < 1500; n++) begin
            s_r  = ($urandom_range(0, 299) == 0);
            s_rd = 1'b0;
            s_wr = 1'b0;
            s_a  = ($urandom_range(0, 3) << 13) | ($urandom_range(0, 15) << 5) | $urandom_range(0, 31);
            s_d  = {$urandom, $urandom};
            if (wbusy) begin
                s_wr = ($urandom_range(0, 3) != 0);
                s_rd = ($urandom_range(0, 7) == 0);
                if (s_wr) s_a = waddr;
            end else begin
                sel  = $urandom_range(0, 9);
                s_wr = (sel < 2);
                s_rd = (sel == 0) || (sel >= 2 && sel < 7);
            end
            tick(s_r, s_rd, s_wr, s_a, s_d);
        end
        idle(20);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
